// File: rtl/adder_result_accumulator.sv
// Frame accumulator behind the 4-bit ripple-carry adder: sums NUM_TERMS {Cout,Sum}
// terms into Total and presents the frame on a valid/ready output with a sticky overflow.
module adder_result_accumulator #(
    parameter int ACC_WIDTH = 8,
    parameter int NUM_TERMS = 4,
    parameter int CNT_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           Sum,
    input  logic                 Cout,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] Total,
    output logic                 Ovf,
    output logic [CNT_W-1:0]     term_count
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t               state_reg, state_next;
    logic [ACC_WIDTH-1:0] total_reg, total_next;
    logic                 ovf_reg, ovf_next;
    logic [CNT_W-1:0]     count_reg, count_next;

    logic [ACC_WIDTH-1:0] term;
    logic [ACC_WIDTH:0]   sum_wide;
    logic                 accept;
    logic                 last_term;
    logic                 handshake;

    // The extra MSB of sum_wide is the carry out of the ACC_WIDTH-bit add.
    assign term      = ACC_WIDTH'({Cout, Sum});
    assign sum_wide  = {1'b0, total_reg} + {1'b0, term};

    assign in_ready  = (state_reg == ACCUM) && !clear;
    assign accept    = in_valid && in_ready;
    assign last_term = (count_reg == CNT_W'(NUM_TERMS - 1));
    assign handshake = (state_reg == HOLD) && out_ready;

    always_comb begin
        state_next = state_reg;
        total_next = total_reg;
        ovf_next   = ovf_reg;
        count_next = count_reg;

        if (clear) begin
            // Abort wins over both accept and the output handshake.
            state_next = ACCUM;
            total_next = '0;
            ovf_next   = 1'b0;
            count_next = '0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (accept) begin
                        total_next = sum_wide[ACC_WIDTH-1:0];
                        ovf_next   = ovf_reg | sum_wide[ACC_WIDTH];
                        count_next = count_reg + CNT_W'(1);
                        if (last_term) begin
                            state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (handshake) begin
                        state_next = ACCUM;
                        total_next = '0;
                        ovf_next   = 1'b0;
                        count_next = '0;
                    end
                end
                default: begin
                    state_next = ACCUM;
                    total_next = '0;
                    ovf_next   = 1'b0;
                    count_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ACCUM;
            total_reg <= '0;
            ovf_reg   <= 1'b0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            total_reg <= total_next;
            ovf_reg   <= ovf_next;
            count_reg <= count_next;
        end
    end

    assign out_valid  = (state_reg == HOLD);
    assign Total      = total_reg;
    assign Ovf        = ovf_reg;
    assign term_count = count_reg;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Scoreboard bench: two accumulators (8-bit and 6-bit totals) share one stimulus stream;
// expected frames are queued at issue time and a monitor checks each output handshake.
`timescale 1ns/1ps
module tb_adder_result_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] Sum = 4'd0;
    logic       Cout = 1'b0;
    logic       clear = 1'b0;
    logic       out_ready = 1'b0;

    logic       ir8, ov8, ovf8;
    logic [7:0] tot8;
    logic [2:0] cnt8;
    logic       ir6, ov6, ovf6;
    logic [5:0] tot6;
    logic [2:0] cnt6;

    int total_cnt = 0;
    int bad_cnt   = 0;

    typedef struct {
        int total;
        int ovf;
    } frame_t;

    frame_t q8[$];
    frame_t q6[$];

    always #5 clk = ~clk;

    adder_result_accumulator #(.ACC_WIDTH(8), .NUM_TERMS(4), .CNT_W(3)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8),
        .Sum(Sum), .Cout(Cout), .clear(clear), .out_valid(ov8),
        .out_ready(out_ready), .Total(tot8), .Ovf(ovf8), .term_count(cnt8)
    );

    adder_result_accumulator #(.ACC_WIDTH(6), .NUM_TERMS(4), .CNT_W(3)) u6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir6),
        .Sum(Sum), .Cout(Cout), .clear(clear), .out_valid(ov6),
        .out_ready(out_ready), .Total(tot6), .Ovf(ovf6), .term_count(cnt6)
    );

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act != exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic push(input int t8, input int o8, input int t6, input int o6);
        frame_t f;
        f.total = t8; f.ovf = o8; q8.push_back(f);
        f.total = t6; f.ovf = o6; q6.push_back(f);
    endtask

    // Output monitor: a handshake completes on the next edge when clear is low.
    always @(negedge clk) begin
        frame_t f;
        if (rst_n && ov8 && out_ready && !clear) begin
            if (q8.size() == 0) begin
                chk("w8 unexpected frame", 1, 0);
            end else begin
                f = q8.pop_front();
                $display("frame w8 total=%0d ovf=%0d cnt=%0d", tot8, ovf8, cnt8);
                chk("w8 frame total", int'(tot8), f.total);
                chk("w8 frame ovf", int'(ovf8), f.ovf);
                chk("w8 frame count", int'(cnt8), 4);
            end
        end
        if (rst_n && ov6 && out_ready && !clear) begin
            if (q6.size() == 0) begin
                chk("w6 unexpected frame", 1, 0);
            end else begin
                f = q6.pop_front();
                $display("frame w6 total=%0d ovf=%0d cnt=%0d", tot6, ovf6, cnt6);
                chk("w6 frame total", int'(tot6), f.total);
                chk("w6 frame ovf", int'(ovf6), f.ovf);
            end
        end
    end

    task automatic send(input logic c, input logic [3:0] s);
        bit got;
        got = 1'b0;
        in_valid = 1'b1; Cout = c; Sum = s;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (ir8) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("send timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic take_frame();
        bit got;
        got = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (ov8) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("frame timeout", 0, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        // Power-on reset state
        #12;
        chk("por total", int'(tot8), 0);
        chk("por out_valid", int'(ov8), 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("por in_ready after release", int'(ir8), 1);
        @(posedge clk); #1;

        // 1: asynchronous reset mid-frame
        send(1'b0, 4'd5);
        send(1'b1, 4'd3);
        chk("t1 count before reset", int'(cnt8), 2);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t1 total async", int'(tot8), 0);
        chk("t1 ovf async", int'(ovf8), 0);
        chk("t1 count async", int'(cnt8), 0);
        chk("t1 out_valid async", int'(ov8), 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("t1 in_ready after release", int'(ir8), 1);
        @(posedge clk); #1;

        // 2: basic frame 5+19+15+31 = 70 (6-bit: 6, carry on last add)
        push(70, 0, 6, 1);
        send(1'b0, 4'd5);
        send(1'b1, 4'd3);
        send(1'b0, 4'd15);
        chk("t2 out_valid before last", int'(ov8), 0);
        send(1'b1, 4'd15);
        chk("t2 out_valid latency", int'(ov8), 1);
        chk("t2 count in hold", int'(cnt8), 4);
        chk("t2 in_ready in hold", int'(ir8), 0);
        take_frame();

        // 3: overflow, four 31s = 124 (6-bit: 60 with overflow)
        push(124, 0, 60, 1);
        for (int i = 0; i < 4; i++) send(1'b1, 4'd15);
        chk("t3 w6 total", int'(tot6), 60);
        chk("t3 w6 ovf", int'(ovf6), 1);
        take_frame();
        chk("t3 w6 ovf cleared", int'(ovf6), 0);
        chk("t3 w6 total cleared", int'(tot6), 0);

        // 4: backpressure, frame 1+2+3+4 = 10
        push(10, 0, 10, 0);
        send(1'b0, 4'd1);
        send(1'b0, 4'd2);
        send(1'b0, 4'd3);
        send(1'b0, 4'd4);
        in_valid = 1'b1; Sum = 4'd7; Cout = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4 total stable", int'(tot8), 10);
            chk("t4 in_ready low", int'(ir8), 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        take_frame();
        chk("t4 in_ready after handshake", int'(ir8), 1);
        chk("t4 count after handshake", int'(cnt8), 0);

        // 5: bubbles between the terms of test 2
        push(70, 0, 6, 1);
        send(1'b0, 4'd5);  idle(2);
        send(1'b1, 4'd3);  idle(1);
        send(1'b0, 4'd15); idle(3);
        chk("t5 out_valid before last", int'(ov8), 0);
        chk("t5 count before last", int'(cnt8), 3);
        send(1'b1, 4'd15);
        chk("t5 out_valid latency", int'(ov8), 1);
        chk("t5 total", int'(tot8), 70);
        take_frame();

        // 6a: clear at term_count 3 rejects the presented term
        send(1'b0, 4'd9);
        send(1'b0, 4'd9);
        send(1'b0, 4'd9);
        in_valid = 1'b1; Sum = 4'd9; clear = 1'b1;
        @(negedge clk);
        chk("t6 in_ready during clear", int'(ir8), 0);
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        chk("t6 total after clear", int'(tot8), 0);
        chk("t6 count after clear", int'(cnt8), 0);

        // 6b: clear in HOLD beats the output handshake and drops the frame
        for (int i = 0; i < 4; i++) send(1'b0, 4'd2);
        chk("t6 hold reached", int'(ov8), 1);
        clear = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; out_ready = 1'b0;
        chk("t6 out_valid after clear", int'(ov8), 0);
        chk("t6 total after hold clear", int'(tot8), 0);

        // Recovery frame: 8+8+8+8 = 32
        push(32, 0, 32, 0);
        for (int i = 0; i < 4; i++) send(1'b0, 4'd8);
        take_frame();
        idle(2);

        chk("w8 queue drained", q8.size(), 0);
        chk("w6 queue drained", q6.size(), 0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
